fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 115 +++++++++++
 tb/tb_fifo_uart_tx.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from an upstream FIFO and serialises them
// as 8N1 (or 8E1 when PARITY_EN=1) frames, LSB first.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rd_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
  logic              in_bit;
  logic              bit_last;

  assign in_bit   = (state == START) || (state == DATA) ||
                    (state == PARITY) || (state == STOP);
  assign bit_last = (baud_cnt == BAUD_LAST);

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      baud_cnt <= (in_bit && !bit_last) ? baud_cnt + 1'b1 : '0;

      // Rotate rather than shift: after 8 bits the register holds the byte
      // again, so the parity bit can be taken straight from it.
      if (state == LATCH)
        shift_reg <= fifo_rd_data;
      else if (state == DATA && bit_last)
        shift_reg <= {shift_reg[0], shift_reg[7:1]};

      if (state != DATA)
        bit_idx <= '0;
      else if (bit_last)
        bit_idx <= bit_idx + 1'b1;
    end
  end

  // Outputs decode from state only, so a reset drives tx high without a clock.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_next = state;
    tx         = 1'b1;
    busy       = 1'b1;
    fifo_rd_en = 1'b0;
    tx_done    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (en && !fifo_empty) state_next = FETCH;
      end
      FETCH: begin
        fifo_rd_en = 1'b1;
        state_next = LATCH;
      end
      LATCH: state_next = START;
      START: begin
        tx = 1'b0;
        if (bit_last) state_next = DATA;
      end
      DATA: begin
        tx = shift_reg[0];
        if (bit_last && bit_idx == 3'd7)
          state_next = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: begin
        tx = ^shift_reg;
        if (bit_last) state_next = STOP;
      end
      STOP: begin
        if (bit_last) begin
          tx_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-backed FIFO model feeds two instances
// (no parity / even parity); frames are compared against a bit-list model.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       sel = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rd_data = 8'h00;

  logic en0, en1;
  logic rd_en0, rd_en1, tx0, tx1, busy0, busy1, done0, done1;
  logic tx, busy, tx_done;

  assign en0     = en & ~sel;
  assign en1     = en & sel;
  assign tx      = sel ? tx1 : tx0;
  assign busy    = sel ? busy1 : busy0;
  assign tx_done = sel ? done1 : done0;

  int         checks = 0;
  int         failures = 0;
  int         rd_cnt = 0;
  logic [7:0] q[$];
  logic [7:0] hold = 8'h00;
  bit         pending = 1'b0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst(rst), .en(en0), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(rd_en0), .tx(tx0),
    .busy(busy0), .tx_done(done0)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(rd_en1), .tx(tx1),
    .busy(busy1), .tx_done(done1)
  );

  always #5 clk = ~clk;

  // FIFO model: a pop seen in one cycle presents its data only in the next
  // cycle; otherwise the data bus carries random junk.
  always @(negedge clk) begin
    if (pending) begin
      fifo_rd_data = hold;
      pending      = 1'b0;
    end else begin
      fifo_rd_data = 8'($urandom);
    end
    if (rd_en0 || rd_en1) begin
      rd_cnt++;
      if (q.size() > 0) hold = q.pop_front();
      else              hold = 8'h00;
      pending = 1'b1;
    end
    fifo_empty = (q.size() == 0);
  end

  task automatic push(input logic [7:0] d);
    q.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic flush();
    q.delete();
    fifo_empty = 1'b1;
  endtask

  function automatic int frame_len(input bit par);
    return (par ? 11 : 10) * CPB;
  endfunction

  // Expected line waveform: start, 8 data bits LSB first, optional even
  // parity, stop; each bit held CPB cycles. Index 0 = first START cycle.
  function automatic logic [47:0] model_wave(input logic [7:0] d, input bit par);
    bit          bits[$];
    logic [47:0] w;
    int          k;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (par) bits.push_back(^d);
    bits.push_back(1'b1);
    w = '0;
    k = 0;
    foreach (bits[b])
      for (int c = 0; c < CPB; c++) begin
        w[k] = bits[b];
        k++;
      end
    return w;
  endfunction

  function automatic logic [47:0] model_done(input bit par);
    return 48'(1) << (frame_len(par) - 1);
  endfunction

  function automatic logic [47:0] model_busy(input bit par);
    return (48'(1) << frame_len(par)) - 48'(1);
  endfunction

  // Records n cycles from the first START cycle; optionally drops en at one index.
  task automatic capture(input int n, input int drop_at,
                         output logic [47:0] txw, output logic [47:0] busyw,
                         output logic [47:0] donew, output bit timeout);
    int waited;
    txw = '0; busyw = '0; donew = '0; timeout = 1'b0; waited = 0;
    while (tx !== 1'b0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (tx !== 1'b0) begin
      timeout = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (i == drop_at) en = 1'b0;
      txw[i]   = tx;
      busyw[i] = busy;
      donew[i] = tx_done;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({tx0, tx1, busy0, busy1, rd_en0, rd_en1, done0, done1} !== 8'b1100_0000) begin
      failures++;
      $display("FAIL reset_async: got %b want 11000000",
               {tx0, tx1, busy0, busy1, rd_en0, rd_en1, done0, done1});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({tx0, tx1, busy0, busy1, rd_en0, rd_en1, done0, done1} !== 8'b1100_0000) begin
      failures++;
      $display("FAIL reset_held: got %b want 11000000",
               {tx0, tx1, busy0, busy1, rd_en0, rd_en1, done0, done1});
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [47:0] txw, busyw, donew;
    logic [9:0]  centers;
    bit          to;
    sel = 1'b0;
    @(negedge clk);
    rd_cnt = 0;
    push(8'hA5);
    en = 1'b1;
    capture(frame_len(0), -1, txw, busyw, donew, to);
    checks++;
    if (to) begin failures++; $display("FAIL single_start: no start bit within 200 cycles"); end
    checks++;
    if (txw !== model_wave(8'hA5, 0)) begin
      failures++;
      $display("FAIL single_tx: got %h want %h", txw, model_wave(8'hA5, 0));
    end
    for (int b = 0; b < 10; b++) centers[b] = txw[b*CPB + 2];
    checks++;
    if (centers !== 10'b11_0100_1010) begin
      failures++;
      $display("FAIL single_bits: got %b want 1101001010", centers);
    end
    checks++;
    if (donew !== model_done(0)) begin
      failures++;
      $display("FAIL single_done: got %h want %h", donew, model_done(0));
    end
    checks++;
    if (busyw !== model_busy(0)) begin
      failures++;
      $display("FAIL single_busy: got %h want %h", busyw, model_busy(0));
    end
    @(negedge clk);
    checks++;
    if ({busy, tx, tx_done} !== 3'b010) begin
      failures++;
      $display("FAIL single_after: got %b want 010", {busy, tx, tx_done});
    end
    checks++;
    if (rd_cnt !== 1) begin failures++; $display("FAIL single_pops: got %0d want 1", rd_cnt); end
    en = 1'b0;
  endtask

  task automatic test_parity();
    logic [47:0] txw, busyw, donew;
    logic [7:0]  vals[2] = '{8'hA5, 8'h01};
    logic        pbit[2] = '{1'b0, 1'b1};
    bit          to;
    sel = 1'b1;
    @(negedge clk);
    rd_cnt = 0;
    for (int v = 0; v < 2; v++) begin
      push(vals[v]);
      en = 1'b1;
      capture(frame_len(1), -1, txw, busyw, donew, to);
      checks++;
      if (to) begin failures++; $display("FAIL parity_start: no start bit for %h", vals[v]); end
      checks++;
      if (txw[39:36] !== {4{pbit[v]}}) begin
        failures++;
        $display("FAIL parity_bit: data %h got %b want %b", vals[v], txw[39:36], {4{pbit[v]}});
      end
      checks++;
      if (txw !== model_wave(vals[v], 1)) begin
        failures++;
        $display("FAIL parity_tx: data %h got %h want %h", vals[v], txw, model_wave(vals[v], 1));
      end
      checks++;
      if (donew !== model_done(1)) begin
        failures++;
        $display("FAIL parity_len: got %h want %h", donew, model_done(1));
      end
      @(negedge clk);
      checks++;
      if ({busy, tx} !== 2'b01) begin
        failures++;
        $display("FAIL parity_after: got %b want 01", {busy, tx});
      end
      en = 1'b0;
    end
    checks++;
    if (rd_cnt !== 2) begin failures++; $display("FAIL parity_pops: got %0d want 2", rd_cnt); end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [47:0] txw1, txw2, busyw, donew1, donew2;
    bit          to1, to2;
    int          gap, k;
    sel = 1'b0;
    @(negedge clk);
    rd_cnt = 0;
    push(8'h3C);
    push(8'hC3);
    en = 1'b1;
    capture(frame_len(0), -1, txw1, busyw, donew1, to1);
    gap = 0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (tx === 1'b1) gap++;
    end while (tx === 1'b1 && k < 20);
    capture(frame_len(0), -1, txw2, busyw, donew2, to2);
    checks++;
    if (to1 || to2) begin failures++; $display("FAIL b2b_start: timeout f1=%0d f2=%0d", to1, to2); end
    checks++;
    if (txw1 !== model_wave(8'h3C, 0) || donew1 !== model_done(0)) begin
      failures++;
      $display("FAIL b2b_frame1: got %h want %h", txw1, model_wave(8'h3C, 0));
    end
    checks++;
    if (txw2 !== model_wave(8'hC3, 0) || donew2 !== model_done(0)) begin
      failures++;
      $display("FAIL b2b_frame2: got %h want %h", txw2, model_wave(8'hC3, 0));
    end
    checks++;
    if (gap !== 3) begin failures++; $display("FAIL b2b_gap: got %0d want 3", gap); end
    checks++;
    if (rd_cnt !== 2) begin failures++; $display("FAIL b2b_pops: got %0d want 2", rd_cnt); end
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic test_idle_guard();
    int bad;
    sel = 1'b0;
    @(negedge clk);
    rd_cnt = 0;
    flush();
    en = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (rd_en0 || rd_en1 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL empty_guard: bad cycles %0d want 0", bad); end
    en = 1'b0;
    push(8'h77);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (rd_en0 || rd_en1 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL disable_guard: bad cycles %0d want 0", bad); end
    checks++;
    if (rd_cnt !== 0) begin failures++; $display("FAIL guard_pops: got %0d want 0", rd_cnt); end
    flush();
  endtask

  task automatic test_en_drop();
    logic [47:0] txw, busyw, donew;
    bit          to;
    int          bad;
    sel = 1'b0;
    @(negedge clk);
    rd_cnt = 0;
    push(8'h55);
    push(8'h99);
    en = 1'b1;
    capture(frame_len(0), 16 + 1, txw, busyw, donew, to);
    checks++;
    if (to || txw !== model_wave(8'h55, 0) || donew !== model_done(0)) begin
      failures++;
      $display("FAIL endrop_frame: got %h want %h timeout %0d", txw, model_wave(8'h55, 0), to);
    end
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL endrop_idle: bad cycles %0d want 0", bad); end
    checks++;
    if (rd_cnt !== 1 || q.size() !== 1) begin
      failures++;
      $display("FAIL endrop_pops: pops %0d left %0d want 1 and 1", rd_cnt, q.size());
    end
    flush();
  endtask

  task automatic test_mid_reset();
    logic [47:0] txw, busyw, donew;
    bit          to;
    int          waited, bad;
    sel = 1'b0;
    @(negedge clk);
    rd_cnt = 0;
    push(8'h5A);
    en = 1'b1;
    waited = 0;
    while (tx !== 1'b0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (tx !== 1'b0) begin failures++; $display("FAIL mrst_start: no start bit within 200 cycles"); end
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({tx, busy, tx_done, rd_en0} !== 4'b1000) begin
      failures++;
      $display("FAIL mrst_async: got %b want 1000", {tx, busy, tx_done, rd_en0});
    end
    @(negedge clk);
    push(8'hE7);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (rd_en0 || rd_en1 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL mrst_held: bad cycles %0d want 0", bad); end
    rst = 1'b0;
    capture(frame_len(0), -1, txw, busyw, donew, to);
    checks++;
    if (to || txw !== model_wave(8'hE7, 0) || donew !== model_done(0)) begin
      failures++;
      $display("FAIL mrst_frame: got %h want %h timeout %0d", txw, model_wave(8'hE7, 0), to);
    end
    checks++;
    if (rd_cnt !== 2) begin failures++; $display("FAIL mrst_pops: got %0d want 2", rd_cnt); end
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic test_random();
    logic [47:0] txw, busyw, donew;
    logic [7:0]  d;
    bit          to, par;
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      par = 1'($urandom_range(0, 1));
      sel = par;
      d   = 8'($urandom);
      push(d);
      en = 1'b1;
      capture(frame_len(par), -1, txw, busyw, donew, to);
      checks++;
      if (to || txw !== model_wave(d, par) || donew !== model_done(par)) begin
        failures++;
        $display("FAIL random_frame: data %h par %0d got %h want %h", d, par, txw, model_wave(d, par));
      end
      @(negedge clk);
      en = 1'b0;
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_idle_guard();
    test_en_drop();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
